spike_event_fifo: RTL and testbench
===================================

SPIKE_EVENT_FIFO -- requirements
Module: spike_event_fifo

Interface
REQ-001 Parameter: TAG_W, default 1, width of the source-neuron tag.
REQ-002 Parameter: DEPTH, default 8, entry count; a power of two, at least 2.
REQ-003 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port: asyn_reset  input  1  reset, asynchronous and active-low (0 = reset).
REQ-005 Port: spike_valid  input  1  a neuron fired this cycle; enqueue request.
REQ-006 Port: spike_tag  input  TAG_W  index of the firing neuron.
REQ-007 Port: req_deq  input  1  dequeue request from synaptic_processing_unit2.
REQ-008 Port: fifo_empty  output  1  queue holds no entries.
REQ-009 Port: fifo_full  output  1  queue holds DEPTH entries.
REQ-010 Port: src_tag_out  output  TAG_W  head entry, first-word fall-through.
REQ-011 Port: count  output  $clog2(DEPTH)+1  current occupancy.
REQ-012 Port: overflow  output  1  sticky flag: a spike was dropped.
REQ-013 Port: clear_ovf  input  1  synchronous clear of overflow and of the drop counter.

Function
REQ-014 Storage SHALL be a circular buffer with read and write pointers of $clog2(DEPTH) bits that wrap from DEPTH-1 to 0.
REQ-015 src_tag_out SHALL present the head entry combinationally while fifo_empty=0; it is all-zero when empty.
REQ-016 Enqueue SHALL occur when spike_valid=1 and either fifo_full=0, or fifo_full=1 with req_deq=1 in the same cycle.
REQ-017 Dequeue SHALL occur when req_deq=1 and fifo_empty=0; req_deq while empty is ignored with no state change.
REQ-018 Simultaneous enqueue and dequeue SHALL leave count unchanged and advance both pointers.
REQ-019 Enqueue when empty SHALL make the entry visible on src_tag_out one cycle later (fifo_empty deasserts after the edge).
REQ-020 Enqueue when full without a dequeue SHALL drop the spike and set overflow=1 on the next edge; stored contents stay unchanged.
REQ-021 overflow SHALL hold until clear_ovf=1; a drop in the same cycle as clear_ovf SHALL leave overflow=1 (set wins).
REQ-022 fifo_empty SHALL equal (count==0) and fifo_full SHALL equal (count==DEPTH), both registered-consistent with count.

Reset
REQ-023 asyn_reset=0 SHALL immediately clear both pointers, count and overflow, force fifo_empty=1, fifo_full=0 and src_tag_out=0, and clear the drop counter when it is compiled in.
REQ-024 Storage array contents need no reset; reset during an in-flight enqueue or dequeue SHALL discard it.

Configuration
REQ-025 With macro SPIKE_FIFO_DROP_CNT_EN defined, an extra output drop_cnt (16 bits) SHALL count dropped spikes, saturate at 16'hFFFF, and clear on reset or clear_ovf.
REQ-026 Without SPIKE_FIFO_DROP_CNT_EN, port drop_cnt and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-027 The shared package SHALL hold the default TAG_W, the default DEPTH, and DROP_CNT_W=16 for reuse by synaptic_processing_unit2 and the neuron units.
REQ-028 The design SHALL be a single module with no sub-modules; pointer/count control and storage stay inline.

Verification
REQ-029 Reset with spike_valid=1 held -> fifo_empty=1, count=0, overflow=0, src_tag_out=0 throughout reset.
REQ-030 Enqueue tag 1 into empty queue -> after the edge fifo_empty=0, src_tag_out=1, count=1; req_deq one cycle -> fifo_empty=1, count=0.
REQ-031 Enqueue 8 alternating tags 0,1,... (DEPTH=8) -> fifo_full=1, count=8; 9th spike -> dropped, overflow=1, count=8; dequeue 8 -> tags out in order 0,1,0,1,...
REQ-032 Full queue with spike_valid=1 and req_deq=1 in the same cycle -> count stays 8, no overflow, new tag appears at the tail.
REQ-033 Queue with 3 entries, 12 cycles of enqueue+dequeue -> pointers wrap past 7, order preserved, count=3 throughout.
REQ-034 With SPIKE_FIFO_DROP_CNT_EN: 5 drops while full -> drop_cnt=5; clear_ovf=1 -> drop_cnt=0 and overflow=0 on the next edge.

Source files
------------

// File: rtl/spike_event_fifo_pkg.sv
// Shared constants for the spike event queue and its neighbours
// (synaptic_processing_unit2 and the neuron units).
package spike_event_fifo_pkg;

  // Default width of the source-neuron tag.
  localparam int TAG_W_DEFAULT = 1;

  // Default queue depth; must be a power of two, at least 2.
  localparam int DEPTH_DEFAULT = 8;

  // Width of the optional dropped-spike counter.
  localparam int DROP_CNT_W = 16;

endpackage : spike_event_fifo_pkg

// File: rtl/spike_event_fifo.sv
// Spike event FIFO: a circular buffer of firing-neuron tags between the
// neuron units and synaptic_processing_unit2. The head entry is shown on
// src_tag_out as soon as it is stored (first-word fall-through).
// A spike that arrives while the queue is full, with no dequeue in the same
// cycle, is dropped and sets the sticky overflow flag.
// Optional feature: define SPIKE_FIFO_DROP_CNT_EN to add a saturating
// 16-bit drop_cnt output that counts dropped spikes.
module spike_event_fifo
  import spike_event_fifo_pkg::*;
#(
  parameter int TAG_W = TAG_W_DEFAULT,
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic                       clk,
  input  logic                       asyn_reset,
  input  logic                       spike_valid,
  input  logic [TAG_W-1:0]           spike_tag,
  input  logic                       req_deq,
  input  logic                       clear_ovf,
  output logic                       fifo_empty,
  output logic                       fifo_full,
  output logic [TAG_W-1:0]           src_tag_out,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow
`ifdef SPIKE_FIFO_DROP_CNT_EN
  ,
  output logic [DROP_CNT_W-1:0]      drop_cnt
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [TAG_W-1:0] mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  logic is_empty;
  logic is_full;
  logic do_enq;
  logic do_deq;
  logic do_drop;

  // Decode the cycle's transfer and compute the next pointers, count and flag.
  // NOTE: every signal assigned here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    is_empty = (cnt_q == '0);
    is_full  = (cnt_q == CNT_W'(DEPTH));
    do_deq   = req_deq & ~is_empty;
    // A full queue still accepts a spike when a dequeue frees a slot this cycle.
    do_enq   = spike_valid & (~is_full | do_deq);
    do_drop  = spike_valid & ~do_enq;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;

    // Pointers are PTR_W bits wide, so they wrap from DEPTH-1 to 0 for free.
    if (do_enq) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_deq) rd_ptr_d = rd_ptr_q + PTR_W'(1);

    unique case ({do_enq, do_deq})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase

    // Clear first, then let a drop in the same cycle set it again.
    if (clear_ovf) ovf_d = 1'b0;
    if (do_drop)   ovf_d = 1'b1;
  end

  // Control state register: pointers, occupancy and overflow flag.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples values from before the edge, independent of block ordering.
  always_ff @(posedge clk or negedge asyn_reset) begin
    if (!asyn_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
    end
  end

  // Tag storage write port.
  // NOTE: the array has no reset; an entry is only ever read after it has
  // been written, and reset clears the pointers that make entries visible.
  always_ff @(posedge clk) begin
    if (do_enq) mem[wr_ptr_q] <= spike_tag;
  end

  // Outputs follow the registered count; the head is forced to zero when empty.
  always_comb begin
    fifo_empty  = is_empty;
    fifo_full   = is_full;
    count       = cnt_q;
    overflow    = ovf_q;
    src_tag_out = is_empty ? '0 : mem[rd_ptr_q];
  end

`ifdef SPIKE_FIFO_DROP_CNT_EN
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  // Saturating count of dropped spikes; clear_ovf restarts it, a same-cycle drop still counts.
  always_comb begin
    drop_cnt_d = clear_ovf ? '0 : drop_cnt_q;
    if (do_drop && (drop_cnt_d != '1)) drop_cnt_d = drop_cnt_d + DROP_CNT_W'(1);
  end

  // Drop counter register.
  always_ff @(posedge clk or negedge asyn_reset) begin
    if (!asyn_reset) drop_cnt_q <= '0;
    else             drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt = drop_cnt_q;
`endif

endmodule : spike_event_fifo

// File: tb/tb_spike_event_fifo.sv
// Testbench for spike_event_fifo. Directed stimulus; expected tags are
// queued when a spike is issued and a negedge monitor pops and compares
// them whenever the DUT performs a dequeue. Covers drop_cnt when built with
// SPIKE_FIFO_DROP_CNT_EN.
module tb_spike_event_fifo;
  import spike_event_fifo_pkg::*;

  localparam int TAG_W = 4;
  localparam int DEPTH = 8;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             clk;
  logic             asyn_reset;
  logic             spike_valid;
  logic [TAG_W-1:0] spike_tag;
  logic             req_deq;
  logic             clear_ovf;
  logic             fifo_empty;
  logic             fifo_full;
  logic [TAG_W-1:0] src_tag_out;
  logic [CNT_W-1:0] count;
  logic             overflow;
`ifdef SPIKE_FIFO_DROP_CNT_EN
  logic [DROP_CNT_W-1:0] drop_cnt;
`endif

  spike_event_fifo #(.TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .asyn_reset  (asyn_reset),
    .spike_valid (spike_valid),
    .spike_tag   (spike_tag),
    .req_deq     (req_deq),
    .clear_ovf   (clear_ovf),
    .fifo_empty  (fifo_empty),
    .fifo_full   (fifo_full),
    .src_tag_out (src_tag_out),
    .count       (count),
    .overflow    (overflow)
`ifdef SPIKE_FIFO_DROP_CNT_EN
    ,
    .drop_cnt    (drop_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Scoreboard of tags expected at the head, oldest first.
  logic [TAG_W-1:0] exp_q [$];

  // Reference occupancy and overflow flag.
  int   model_cnt = 0;
  logic model_ovf = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_state(input string name);
    check({name, "_count"}, 32'(count), 32'(model_cnt));
    check({name, "_empty"}, 32'(fifo_empty), 32'(model_cnt == 0));
    check({name, "_full"},  32'(fifo_full),  32'(model_cnt == DEPTH));
    check({name, "_ovf"},   32'(overflow),   32'(model_ovf));
  endtask

  // One clock cycle of stimulus; called at posedge+1, returns at the next posedge+1.
  task automatic step(input string name, input logic v, input logic [TAG_W-1:0] t,
                      input logic d, input logic c);
    logic deq, enq;
    spike_valid = v;
    spike_tag   = t;
    req_deq     = d;
    clear_ovf   = c;
    deq = d && (model_cnt != 0);
    enq = v && ((model_cnt != DEPTH) || deq);
    if (enq) exp_q.push_back(t);
    if (v && !enq)  model_ovf = 1'b1;
    else if (c)     model_ovf = 1'b0;
    model_cnt = model_cnt + int'(enq) - int'(deq);
    @(posedge clk);
    #1;
    spike_valid = 1'b0;
    req_deq     = 1'b0;
    clear_ovf   = 1'b0;
    check_state(name);
  endtask

  // Monitor: compares the head against the scoreboard on every dequeue.
  always @(negedge clk) begin
    logic [TAG_W-1:0] exp_tag;
    if (asyn_reset) begin
      if (fifo_empty) begin
        check("empty_tag_zero", 32'(src_tag_out), 32'd0);
      end else if (req_deq) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL deq_unexpected: got tag %0h expected no entry (t=%0t)", src_tag_out, $time);
        end else begin
          exp_tag = exp_q.pop_front();
          check("deq_order", 32'(src_tag_out), 32'(exp_tag));
        end
      end
    end
  end

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    asyn_reset  = 1'b0;
    spike_valid = 1'b1;
    spike_tag   = 4'hA;
    req_deq     = 1'b0;
    clear_ovf   = 1'b0;

    // Reset held with a spike pending: queue stays empty throughout.
    repeat (3) begin
      @(negedge clk);
      check("rst_empty", 32'(fifo_empty), 32'd1);
      check("rst_full",  32'(fifo_full),  32'd0);
      check("rst_count", 32'(count),      32'd0);
      check("rst_ovf",   32'(overflow),   32'd0);
      check("rst_tag",   32'(src_tag_out), 32'd0);
    end
    @(posedge clk);
    #1;
    asyn_reset  = 1'b1;
    spike_valid = 1'b0;
    spike_tag   = '0;

    // Single enqueue into empty queue, then dequeue.
    step("enq1", 1'b1, 4'h1, 1'b0, 1'b0);
    check("enq1_tag", 32'(src_tag_out), 32'd1);
    check("enq1_cnt_const", 32'(count), 32'd1);
    step("deq1", 1'b0, 4'h0, 1'b1, 1'b0);
    check("deq1_empty_const", 32'(fifo_empty), 32'd1);

    // Fill with alternating tags 0,1,...
    for (int i = 0; i < DEPTH; i++) step("fill", 1'b1, TAG_W'(i % 2), 1'b0, 1'b0);
    check("fill_full_const", 32'(fifo_full), 32'd1);
    check("fill_cnt_const",  32'(count),     32'd8);

    // Full with simultaneous enqueue and dequeue: no drop, count holds.
    step("full_pass", 1'b1, 4'h7, 1'b1, 1'b0);
    check("full_pass_cnt", 32'(count),    32'd8);
    check("full_pass_ovf", 32'(overflow), 32'd0);

    // Five drops while full.
    for (int i = 0; i < 5; i++) step("drop", 1'b1, 4'h9, 1'b0, 1'b0);
    check("drop_ovf_const", 32'(overflow), 32'd1);
    check("drop_cnt8",      32'(count),    32'd8);
`ifdef SPIKE_FIFO_DROP_CNT_EN
    check("drop_cnt_5", 32'(drop_cnt), 32'd5);
`endif
    step("clr", 1'b0, 4'h0, 1'b0, 1'b1);
    check("clr_ovf_const", 32'(overflow), 32'd0);
`ifdef SPIKE_FIFO_DROP_CNT_EN
    check("clr_drop_cnt", 32'(drop_cnt), 32'd0);
`endif

    // Drop and clear in the same cycle: set wins.
    step("drop_clr", 1'b1, 4'h9, 1'b0, 1'b1);
    check("drop_clr_ovf", 32'(overflow), 32'd1);
    step("clr2", 1'b0, 4'h0, 1'b0, 1'b1);

    // Drain: order 1,0,1,0,1,0,1,7 checked by the monitor.
    for (int i = 0; i < DEPTH; i++) step("drain", 1'b0, 4'h0, 1'b1, 1'b0);
    // Dequeue while empty changes nothing.
    step("deq_empty", 1'b0, 4'h0, 1'b1, 1'b0);

    // Three entries, then 12 cycles of enqueue+dequeue across the pointer wrap.
    for (int i = 0; i < 3; i++) step("pre3", 1'b1, TAG_W'(4'hA + i), 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) begin
      step("wrap", 1'b1, TAG_W'(i + 3), 1'b1, 1'b0);
      check("wrap_cnt3", 32'(count), 32'd3);
    end
    for (int i = 0; i < 3; i++) step("post3", 1'b0, 4'h0, 1'b1, 1'b0);

    // Asynchronous reset in mid-cycle discards queued entries at once.
    step("pre_rst", 1'b1, 4'h5, 1'b0, 1'b0);
    step("pre_rst", 1'b1, 4'h6, 1'b0, 1'b0);
    #2;
    asyn_reset = 1'b0;
    #1;
    check("arst_count", 32'(count),       32'd0);
    check("arst_empty", 32'(fifo_empty),  32'd1);
    check("arst_tag",   32'(src_tag_out), 32'd0);
    exp_q.delete();
    model_cnt = 0;
    model_ovf = 1'b0;
    @(posedge clk);
    #1;
    asyn_reset = 1'b1;
    step("post_rst", 1'b1, 4'h3, 1'b0, 1'b0);
    check("post_rst_tag", 32'(src_tag_out), 32'd3);
    step("post_rst_deq", 1'b0, 4'h0, 1'b1, 1'b0);

    @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_spike_event_fifo
